abstract_cmd_sequencer: RTL
===========================

ABSTRACT_CMD_SEQUENCER -- requirements
Module: abstract_cmd_sequencer

Interface
REQ-001 SHALL have parameter OPC_REG, default 5'b10000, microcode address of register access.
REQ-002 SHALL have parameter OPC_NA, default 5'b10001, microcode address of no-access (skip transfer).
REQ-003 SHALL have parameter OPC_EXEC, default 5'b10010, microcode address of program-buffer execution.
REQ-004 SHALL have parameter OPC_RMEM, default 5'b10100, memory-read first phase; second phase is OPC_RMEM+1.
REQ-005 SHALL have parameter OPC_WMEM, default 5'b10110, memory-write first phase; second phase is OPC_WMEM+1.
REQ-006 SHALL have parameter EXEC_TIMEOUT, default 1024, max cycles for program-buffer execution.
REQ-007 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-009 SHALL have ports cmd_valid input 1 / cmd_ready output 1  command handshake.
REQ-010 SHALL have port cmd_type  input  8  0 = access register, 2 = access memory, other = unsupported.
REQ-011 SHALL have ports cmd_transfer, cmd_write, cmd_postexec  input  1 each  command fields.
REQ-012 SHALL have port halted  input  1  hart is halted.
REQ-013 SHALL have port resumereq  input  1  request to resume hart.
REQ-014 SHALL have port step_done  input  1  hart finished current microcode step.
REQ-015 SHALL have port exec_exception  input  1  hart trapped during program-buffer execution.
REQ-016 SHALL have port mcp_addr  output  5  microcode address presented to hart.
REQ-017 SHALL have ports abstract_write, progbuf, abstract_done, busy  output  1 each.
REQ-018 SHALL have port cmderr  output  3  sticky error: 0 none, 1 busy, 2 not supported, 3 exception, 4 halt/resume.
REQ-019 SHALL have port cmderr_clr  input  1  clears cmderr to 0.

Function
REQ-020 SHALL implement states IDLE, REG, NA, RMEM, RMEM_1, WMEM, WMEM_1, EXEC, DONE, RESUMING.
REQ-021 mcp_addr SHALL be: IDLE 5'b01110, RESUMING 5'b01111, REG OPC_REG, NA OPC_NA, EXEC OPC_EXEC, RMEM/RMEM_1 OPC_RMEM/+1, WMEM/WMEM_1 OPC_WMEM/+1, DONE 5'b01110.
REQ-022 cmd_ready SHALL equal (state==IDLE && cmderr==0 && halted); accept on cmd_valid && cmd_ready.
REQ-023 On accept: cmd_type 0 with cmd_transfer -> REG; cmd_type 0 without transfer -> NA; cmd_type 2 -> RMEM if !cmd_write else WMEM; other -> cmderr=2, stay IDLE.
REQ-024 cmd_write, cmd_postexec SHALL be latched at accept; abstract_write = latched cmd_write in REG/WMEM/WMEM_1, else 0.
REQ-025 REG, NA, RMEM_1, WMEM_1: on step_done advance to EXEC if postexec latched, else DONE.
REQ-026 RMEM->RMEM_1 and WMEM->WMEM_1 on step_done.
REQ-027 EXEC: progbuf=1; 10-bit-plus counter from 0; step_done -> DONE; exec_exception -> cmderr=3, DONE; counter reaching EXEC_TIMEOUT-1 without either -> cmderr=3, DONE.
REQ-028 exec_exception and step_done same cycle in EXEC: exception wins.
REQ-029 DONE: abstract_done=1 for exactly one cycle, then IDLE.
REQ-030 busy = 1 in every state except IDLE.
REQ-031 cmd_valid while busy SHALL set cmderr=1 if cmderr==0; command dropped.
REQ-032 cmd_valid in IDLE with !halted SHALL set cmderr=4 if cmderr==0; command dropped.
REQ-033 cmderr SHALL be sticky: only first nonzero error recorded; cmderr_clr wins over a same-cycle new error.
REQ-034 resumereq in IDLE with halted and no same-cycle accept -> RESUMING; leave to IDLE when halted deasserts; resumereq while busy ignored.
REQ-035 halted deasserting during any command state SHALL abort to DONE with cmderr=4.

Reset
REQ-036 rst_n low SHALL asynchronously force IDLE, cmderr=0, counter=0, latched fields=0; outputs: mcp_addr=5'b01110, cmd_ready=0 until halted, busy=0, progbuf=0, abstract_write=0, abstract_done=0.
REQ-037 Reset mid-command SHALL abandon it with no abstract_done pulse.

Verification
REQ-038 Halted, cmd_type=0, transfer=1, write=1, postexec=0, step_done after 3 cycles -> mcp_addr OPC_REG, abstract_write=1, then abstract_done one cycle, cmderr=0.
REQ-039 cmd_type=2 write=0 postexec=1, step_done thrice -> mcp_addr 10100, 10101, 10010 (progbuf=1), then abstract_done.
REQ-040 cmd_type=5 -> cmderr=2, no state change; second command rejected (cmd_ready=0) until cmderr_clr.
REQ-041 EXEC with no step_done for 1024 cycles -> cmderr=3, abstract_done on cycle 1025.
REQ-042 cmd_valid during WMEM -> cmderr=1, WMEM sequence completes normally.
REQ-043 rst_n low during EXEC -> immediate IDLE, mcp_addr=5'b01110, progbuf=0, no abstract_done.

Source files
------------

// File: rtl/abstract_cmd_sequencer.sv
// Abstract command sequencer for a debug module.
// Accepts abstract commands while the hart is halted, walks the hart through
// the microcode steps for each command, optionally runs the program buffer,
// and records the first error in a sticky cmderr register.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a command or resume request
// REG      | register access microcode step
// NA       | no-access step (command without transfer)
// RMEM     | memory read, first phase
// RMEM_1   | memory read, second phase
// WMEM     | memory write, first phase
// WMEM_1   | memory write, second phase
// EXEC     | program buffer execution, guarded by a timeout counter
// DONE     | one-cycle completion pulse
// RESUMING | resume requested, waiting for the hart to leave halt
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_type[7:0]              0 register, 2 memory, others unsupported
//   cmd_transfer, cmd_write,
//   cmd_postexec               command fields
//   halted, resumereq,
//   step_done, exec_exception  hart status
//   mcp_addr[4:0]              microcode address shown to the hart
//   abstract_write, progbuf,
//   abstract_done, busy        status outputs
//   cmderr[2:0], cmderr_clr    sticky error and its clear
module abstract_cmd_sequencer #(
  parameter logic [4:0] OPC_REG      = 5'b10000,
  parameter logic [4:0] OPC_NA       = 5'b10001,
  parameter logic [4:0] OPC_EXEC     = 5'b10010,
  parameter logic [4:0] OPC_RMEM     = 5'b10100,
  parameter logic [4:0] OPC_WMEM     = 5'b10110,
  parameter int         EXEC_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_type,
  input  logic       cmd_transfer,
  input  logic       cmd_write,
  input  logic       cmd_postexec,
  input  logic       halted,
  input  logic       resumereq,
  input  logic       step_done,
  input  logic       exec_exception,
  output logic [4:0] mcp_addr,
  output logic       abstract_write,
  output logic       progbuf,
  output logic       abstract_done,
  output logic       busy,
  output logic [2:0] cmderr,
  input  logic       cmderr_clr
);

  localparam int CW = $clog2(EXEC_TIMEOUT) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(EXEC_TIMEOUT - 1);

  localparam logic [4:0] ADDR_IDLE   = 5'b01110;
  localparam logic [4:0] ADDR_RESUME = 5'b01111;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_BUSY   = 3'd1;
  localparam logic [2:0] ERR_NOTSUP = 3'd2;
  localparam logic [2:0] ERR_EXCEPT = 3'd3;
  localparam logic [2:0] ERR_HALT   = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_REG      = 4'd1,
    S_NA       = 4'd2,
    S_RMEM     = 4'd3,
    S_RMEM_1   = 4'd4,
    S_WMEM     = 4'd5,
    S_WMEM_1   = 4'd6,
    S_EXEC     = 4'd7,
    S_DONE     = 4'd8,
    S_RESUMING = 4'd9
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_cmderr;
  logic [CW-1:0]   r_cnt;
  logic            r_write;
  logic            r_postexec;

  logic            w_ready;
  logic            w_accept;
  logic            w_cmd_state;
  logic [2:0]      w_fsm_err;
  logic [2:0]      w_new_err;

  assign w_ready     = (r_state == S_IDLE) && (r_cmderr == ERR_NONE) && halted;
  assign w_accept    = cmd_valid && w_ready;
  assign w_cmd_state = (r_state != S_IDLE) && (r_state != S_DONE) &&
                       (r_state != S_RESUMING);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and FSM-generated error code
  always_comb begin
    w_state_nxt = r_state;
    w_fsm_err   = ERR_NONE;
    if (w_cmd_state && !halted) begin
      // losing halt in the middle of a command aborts it
      w_state_nxt = S_DONE;
      w_fsm_err   = ERR_HALT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (cmd_type)
              8'd0:    w_state_nxt = cmd_transfer ? S_REG : S_NA;
              8'd2:    w_state_nxt = cmd_write ? S_WMEM : S_RMEM;
              default: w_fsm_err   = ERR_NOTSUP;
            endcase
          end else if (cmd_valid && !halted) begin
            w_fsm_err = ERR_HALT;
          end else if (resumereq && halted) begin
            w_state_nxt = S_RESUMING;
          end
        end
        S_REG, S_NA, S_RMEM_1, S_WMEM_1: begin
          if (step_done) w_state_nxt = r_postexec ? S_EXEC : S_DONE;
        end
        S_RMEM: if (step_done) w_state_nxt = S_RMEM_1;
        S_WMEM: if (step_done) w_state_nxt = S_WMEM_1;
        S_EXEC: begin
          if (exec_exception) begin
            w_state_nxt = S_DONE;
            w_fsm_err   = ERR_EXCEPT;
          end else if (step_done) begin
            w_state_nxt = S_DONE;
          end else if (r_cnt == TMO_LAST) begin
            w_state_nxt = S_DONE;
            w_fsm_err   = ERR_EXCEPT;
          end
        end
        S_DONE:     w_state_nxt = S_IDLE;
        S_RESUMING: if (!halted) w_state_nxt = S_IDLE;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  // A command arriving while busy is dropped; a state-driven error in the
  // same cycle takes precedence since only one code can be recorded.
  always_comb begin
    w_new_err = w_fsm_err;
    if (w_fsm_err == ERR_NONE && cmd_valid && r_state != S_IDLE) begin
      w_new_err = ERR_BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmderr   <= ERR_NONE;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_postexec <= 1'b0;
    end else begin
      if (cmderr_clr) begin
        r_cmderr <= ERR_NONE;
      end else if (r_cmderr == ERR_NONE) begin
        r_cmderr <= w_new_err;
      end
      if (w_accept) begin
        r_write    <= cmd_write;
        r_postexec <= cmd_postexec;
      end
      if (r_state == S_EXEC && w_state_nxt == S_EXEC) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Outputs
  always_comb begin
    mcp_addr       = ADDR_IDLE;
    abstract_write = 1'b0;
    progbuf        = 1'b0;
    abstract_done  = 1'b0;
    busy           = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:     mcp_addr = ADDR_IDLE;
      S_RESUMING: mcp_addr = ADDR_RESUME;
      S_REG: begin
        mcp_addr       = OPC_REG;
        abstract_write = r_write;
      end
      S_NA:       mcp_addr = OPC_NA;
      S_RMEM:     mcp_addr = OPC_RMEM;
      S_RMEM_1:   mcp_addr = OPC_RMEM + 5'd1;
      S_WMEM: begin
        mcp_addr       = OPC_WMEM;
        abstract_write = r_write;
      end
      S_WMEM_1: begin
        mcp_addr       = OPC_WMEM + 5'd1;
        abstract_write = r_write;
      end
      S_EXEC: begin
        mcp_addr = OPC_EXEC;
        progbuf  = 1'b1;
      end
      S_DONE: begin
        mcp_addr      = ADDR_IDLE;
        abstract_done = 1'b1;
      end
      default:    mcp_addr = ADDR_IDLE;
    endcase
  end

  assign cmd_ready = w_ready;
  assign cmderr    = r_cmderr;

endmodule
